life_stencil_engine: RTL and testbench
======================================

Name: life_stencil_engine

Overview:
- Computes one Game-of-Life generation by streaming the source frame RAM in raster order and writing next-generation cells to the destination frame RAM.
- Sits between the ping-pong 1-bit frame RAMs (RAM_1_524288 instances).
- Uses an internal line-buffer stencil, so each source cell is read exactly once per generation.
- The top level starts it once per evolution tick and steers RAM ports by the evolution phase.

Parameters:
- P_PARAM_M, 600, grid rows.
- P_PARAM_N, 800, grid columns.
- AW, 24, RAM address width; P_PARAM_N*P_PARAM_M must be < 2^AW.

Ports:
- clk  in  1  pixel/system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins one generation when idle.
- busy  out  1  high from the first RUN cycle until the done cycle, inclusive.
- done  out  1  one-cycle pulse after the final write.
- rd_en  out  1  source RAM read enable.
- rd_addr  out  AW  source address, row*P_PARAM_N+col.
- rd_data  in  1  source cell; valid exactly 1 cycle after rd_en (registered RAM output).
- wr_en  out  1  destination write enable.
- wr_addr  out  AW  destination address.
- wr_data  out  1  next-generation cell (1 = live).

Behaviour:
- Reset (async, any time): state IDLE; busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0; shift register cleared.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start=1 clears the shift register and counters, then enters RUN.
  - start is ignored in every other state.
- RUN (cycle r = 0,1,...):
  - rd_en=1, rd_addr=r.
  - After issuing P_PARAM_N*P_PARAM_M-1, go to FLUSH.
- FLUSH:
  - rd_en=0; inject P_PARAM_N+1 zero samples, one per cycle.
  - Then wait for the write pipeline to drain, then go to DONE.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Shift register SR, length 2*P_PARAM_N+3:
  - A sample enters SR[0] on the edge where it becomes valid.
  - Real data arrive 1 cycle after issue; a valid bit is pipelined alongside rd_en.
  - FLUSH zeros shift with valid=1.
- Window and centre:
  - Centre = SR[P_PARAM_N+1], i.e. cell j = k-P_PARAM_N-1 after sample k shifts in.
  - Rows use taps {0,1,2}, {N,N+1,N+2}, {2N,2N+1,2N+2}.
- Edge handling: no wrap-around; outside cells count as dead.
  - Top/bottom edges: zero prefill and zero flush.
  - Left/right edges: a column counter for the centre masks the wrapping taps when col=0 or col=N-1.
- Rule:
  - Neighbour count 0..8 in a 4-bit sum.
  - live_next = (count==3) | (centre & count==2).
- Write stream:
  - Writes are registered; cell j is written once, in increasing order, wr_addr=j.
  - Exactly P_PARAM_N*P_PARAM_M wr_en cycles per generation, no gaps.
  - Latency: with the first RUN cycle as cycle 0, cell j's wr_en is high in cycle j+P_PARAM_N+4.
- Generation length: last write at cycle N*M+N+3; done at N*M+N+4.
- Both RAM sides see contiguous address streams. The same RAM must not be both source and destination; the top level guarantees this.

Decomposition:
- Package life_pkg:
  - state enum (IDLE, RUN, FLUSH, DONE).
  - count width constant (4).
  - localparam helpers for total cells and the SR length.
- Sub-module life_rule (combinational): 3x3 window in, masked per edge flags; live_next out.
- Counters, SR and FSM stay in life_stencil_engine.

Test Plan (P_PARAM_N=8, P_PARAM_M=6 unless noted):
- Latency and order: all-zero source → exactly 48 writes, addresses 0..47 in order, all wr_data=0. First wr_en at cycle 12, done at cycle 60, busy spans cycles 0..60.
- Blinker: horizontal cells at (2,3),(2,4),(2,5) → destination live set is exactly {(1,4),(2,4),(3,4)}. Addresses 12, 20, 28 = 1; all others 0.
- Still life and corner: block at (0,0),(0,1),(1,0),(1,1) stays unchanged. A lone cell at (5,7) dies (addr 47 = 0).
- No wrap: cells (2,7),(3,7),(4,7) on the right edge → (3,6) and (3,7) live; column 0 stays all 0.
- Control:
  - start pulsed mid-RUN → ignored; write count remains 48.
  - rst asserted during FLUSH → all outputs 0 immediately, state IDLE.
  - A subsequent start runs a clean generation with the correct blinker result.
- Full size (600x800): random seed compared against a software model; 480000 writes and done at cycle 480804.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and sizing helpers for the Game-of-Life stencil engine.
//   state_e      : generation controller states
//   COUNT_W      : width of the neighbour count (0..8)
//   total_cells  : cells per frame (rows * columns)
//   sr_len       : line-buffer length for a 3x3 stencil over rows of n cells
package life_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned COUNT_W = 4;

    function automatic int unsigned total_cells(input int unsigned n, input int unsigned m);
        return n * m;
    endfunction

    // Two full rows plus three cells spans the whole 3x3 window.
    function automatic int unsigned sr_len(input int unsigned n);
        return (2 * n) + 3;
    endfunction

endpackage

// File: rtl/life_stencil_engine_rule.sv
// Combinational Game-of-Life rule on a 3x3 window.
//   i_win       : window, bit index = row*3 + col (row 0 = above, col 0 = left)
//   i_col_first : centre sits in column 0, left column is outside the grid
//   i_col_last  : centre sits in the last column, right column is outside the grid
//   o_live_c    : next-generation state of the centre cell
module life_rule
    import life_pkg::*;
(
    input  logic [8:0] i_win,
    input  logic       i_col_first,
    input  logic       i_col_last,
    output logic       o_live_c
);

    logic [8:0]         w_win;
    logic [COUNT_W-1:0] w_cnt;

    // Mask the taps that wrapped around from the neighbouring row, then count.
    always_comb begin
        w_win = i_win;
        if (i_col_first) begin
            w_win[0] = 1'b0;
            w_win[3] = 1'b0;
            w_win[6] = 1'b0;
        end
        if (i_col_last) begin
            w_win[2] = 1'b0;
            w_win[5] = 1'b0;
            w_win[8] = 1'b0;
        end
        w_cnt = '0;
        for (int i = 0; i < 9; i++) begin
            if (i != 4) begin
                w_cnt = w_cnt + COUNT_W'(w_win[i]);
            end
        end
    end

    assign o_live_c = (w_cnt == COUNT_W'(3)) | (w_win[4] & (w_cnt == COUNT_W'(2)));

endmodule

// File: rtl/life_stencil_engine.sv
// One Game-of-Life generation: streams the source frame in raster order once,
// keeps two rows plus three cells in a line buffer, and writes every next-gen
// cell to the destination frame in raster order.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle pulse, accepted only when idle
//   busy, done      : generation in progress / one-cycle completion pulse
//   rd_en, rd_addr  : source read request (data returns one cycle later)
//   rd_data         : source cell
//   wr_en, wr_addr,
//   wr_data         : destination write stream
module life_stencil_engine
    import life_pkg::*;
#(
    parameter int unsigned P_PARAM_M = 600,
    parameter int unsigned P_PARAM_N = 800,
    parameter int unsigned AW        = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          wr_data
);

    localparam int unsigned L_CELLS = total_cells(P_PARAM_N, P_PARAM_M);
    localparam int unsigned L_SR    = sr_len(P_PARAM_N);
    localparam int unsigned CW      = $clog2(P_PARAM_N + 2);
    localparam int unsigned L_N     = P_PARAM_N;

    state_e          r_state;
    state_e          w_next_state;
    logic            w_inject;
    logic            w_start;

    logic            r_busy;
    logic            r_done;
    logic            r_rd_en;
    logic [AW-1:0]   r_rd_addr;
    logic [CW-1:0]   r_flush_cnt;

    logic            r_smp_vld;
    logic            r_smp_zero;
    logic            w_sample;
    logic [L_SR-1:0] r_sr;
    logic [CW-1:0]   r_smp_cnt;

    logic            r_cen_vld;
    logic [AW-1:0]   r_cen_idx;
    logic [CW-1:0]   r_cen_col;
    logic [8:0]      w_win;
    logic            w_live;

    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic            r_wr_data;

    assign w_start = (r_state == IDLE) & start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; FLUSH also decides whether a zero sample is injected this cycle.
    always_comb begin
        w_next_state = r_state;
        w_inject     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (r_rd_addr == AW'(L_CELLS - 1)) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                w_inject = (r_flush_cnt != CW'(L_N + 1));
                if (r_wr_en && (r_wr_addr == AW'(L_CELLS - 1))) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Read issue, status flags and the sample-valid pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_flush_cnt <= '0;
            r_smp_vld   <= 1'b0;
            r_smp_zero  <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            r_done <= (w_next_state == DONE);
            if (w_start) begin
                r_rd_en     <= 1'b1;
                r_rd_addr   <= '0;
                r_flush_cnt <= '0;
            end else if (r_state == RUN) begin
                if (w_next_state == FLUSH) begin
                    r_rd_en <= 1'b0;
                end else begin
                    r_rd_addr <= r_rd_addr + AW'(1);
                end
            end
            if (w_inject) begin
                r_flush_cnt <= r_flush_cnt + CW'(1);
            end
            // Valid tracks rd_en by one cycle, matching the RAM read latency.
            r_smp_vld  <= r_rd_en | w_inject;
            r_smp_zero <= w_inject;
        end
    end

    assign w_sample = r_smp_zero ? 1'b0 : rd_data;

    // Window taps: SR[0] is below-right of the centre, SR[2N+2] above-left.
    assign w_win = {r_sr[0],       r_sr[1],       r_sr[2],
                    r_sr[L_N],     r_sr[L_N+1],   r_sr[L_N+2],
                    r_sr[2*L_N],   r_sr[2*L_N+1], r_sr[2*L_N+2]};

    life_rule u_rule (
        .i_win       (w_win),
        .i_col_first (r_cen_col == CW'(0)),
        .i_col_last  (r_cen_col == CW'(L_N - 1)),
        .o_live_c    (w_live)
    );

    // Line buffer, centre tracking and registered write stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr      <= '0;
            r_smp_cnt <= '0;
            r_cen_vld <= 1'b0;
            r_cen_idx <= '0;
            r_cen_col <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 1'b0;
        end else begin
            if (w_start) begin
                r_sr      <= '0;
                r_smp_cnt <= '0;
                r_cen_vld <= 1'b0;
                r_cen_idx <= '0;
                r_cen_col <= '0;
            end else begin
                if (r_smp_vld) begin
                    r_sr <= {r_sr[L_SR-2:0], w_sample};
                    // Saturates once the first centre cell has reached SR[N+1].
                    if (r_smp_cnt != CW'(L_N + 1)) begin
                        r_smp_cnt <= r_smp_cnt + CW'(1);
                    end
                end
                r_cen_vld <= r_smp_vld && (r_smp_cnt == CW'(L_N + 1));
                if (r_cen_vld) begin
                    r_cen_idx <= r_cen_idx + AW'(1);
                    r_cen_col <= (r_cen_col == CW'(L_N - 1)) ? '0 : r_cen_col + CW'(1);
                end
            end
            r_wr_en <= r_cen_vld;
            if (r_cen_vld) begin
                r_wr_addr <= r_cen_idx;
                r_wr_data <= w_live;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_life_stencil_engine.sv
// Scoreboard bench for life_stencil_engine on an 8x6 grid.
module tb_life_stencil_engine;

    localparam int N  = 8;
    localparam int M  = 6;
    localparam int NM = N * M;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, rd_en, wr_en, wr_data;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          rd_data = 1'b0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t q[$];
    bit   src[NM];
    bit   dst[NM];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   base = 0;
    int   wr_cnt = 0;
    bit   done_seen = 1'b0;
    int   done_rel = 0;

    life_stencil_engine #(.P_PARAM_M(M), .P_PARAM_N(N), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    // Cycle counter, registered source RAM and destination RAM.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en && int'(rd_addr) < NM) rd_data <= src[int'(rd_addr)];
        if (wr_en && int'(wr_addr) < NM) dst[int'(wr_addr)] <= wr_data;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rule: count live in-grid neighbours, no wrap-around.
    function automatic int nxt(input int r, input int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < M &&
                    (c + dc) >= 0 && (c + dc) < N) begin
                    n += int'(src[(r + dr) * N + (c + dc)]);
                end
            end
        end
        return ((n == 3) || (src[r * N + c] && n == 2)) ? 1 : 0;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        for (int j = 0; j < NM; j++) n += int'(dst[j]);
        return n;
    endfunction

    // Monitor: pop the expected write and compare address, data and timing.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                wr_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wr_addr", int'(wr_addr), e.addr);
                    chk("wr_data", int'(wr_data), e.data);
                    chk("wr_cycle", cyc - base, e.cyc);
                end
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_rel  = cyc - base;
            end
        end
    end

    task automatic clear_src();
        for (int j = 0; j < NM; j++) src[j] = 1'b0;
    endtask

    task automatic set_cell(input int r, input int c);
        src[r * N + c] = 1'b1;
    endtask

    task automatic load_model();
        q.delete();
        for (int j = 0; j < NM; j++) begin
            q.push_back('{addr: j, data: nxt(j / N, j % N), cyc: j + N + 4});
            dst[j] <= 1'b1;
        end
        wr_cnt    = 0;
        done_seen = 1'b0;
    endtask

    // Pulse start; returns at #1 after the negedge of the first RUN cycle.
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        base  = cyc + 1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_gen(input bit poke);
        int bad;
        load_model();
        kick();
        chk("busy_first_run", int'(busy), 1);
        chk("rd_en_first_run", int'(rd_en), 1);
        chk("rd_addr_first_run", int'(rd_addr), 0);
        for (int t = 0; t < 200 && !done_seen; t++) begin
            @(negedge clk);
            #1;
            if (poke) start = ((cyc - base) == 20);
        end
        start = 1'b0;
        if (!done_seen) begin
            chk("done_timeout", 0, 1);
            q.delete();
        end else begin
            chk("done_cycle", done_rel, NM + N + 4);
            chk("busy_at_done", int'(busy), 1);
            chk("write_count", wr_cnt, NM);
            chk("queue_drained", q.size(), 0);
            @(negedge clk);
            #1;
            chk("busy_after_done", int'(busy), 0);
            chk("done_one_cycle", int'(done), 0);
            bad = 0;
            for (int j = 0; j < NM; j++) if (int'(dst[j]) != nxt(j / N, j % N)) bad++;
            chk("dst_image", bad, 0);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All-zero source: timing and ordering.
        clear_src();
        run_gen(1'b0);
        chk("zero_live_count", live_cnt(), 0);

        // Blinker.
        clear_src();
        set_cell(2, 3); set_cell(2, 4); set_cell(2, 5);
        run_gen(1'b0);
        chk("blinker_count", live_cnt(), 3);
        chk("blinker_12", int'(dst[12]), 1);
        chk("blinker_20", int'(dst[20]), 1);
        chk("blinker_28", int'(dst[28]), 1);

        // Block in the corner plus a lone cell in the opposite corner.
        clear_src();
        set_cell(0, 0); set_cell(0, 1); set_cell(1, 0); set_cell(1, 1);
        set_cell(5, 7);
        run_gen(1'b0);
        chk("block_count", live_cnt(), 4);
        chk("block_0", int'(dst[0]), 1);
        chk("block_9", int'(dst[9]), 1);
        chk("lone_47", int'(dst[47]), 0);

        // Right-edge column must not wrap into column 0.
        clear_src();
        set_cell(2, 7); set_cell(3, 7); set_cell(4, 7);
        run_gen(1'b0);
        chk("edge_count", live_cnt(), 2);
        chk("edge_30", int'(dst[30]), 1);
        chk("edge_31", int'(dst[31]), 1);
        chk("edge_col0_row3", int'(dst[24]), 0);

        // Random frames, one with a start pulse mid-run.
        for (int g = 0; g < 3; g++) begin
            for (int j = 0; j < NM; j++) src[j] = ($urandom_range(0, 2) == 0);
            run_gen(g == 1);
        end

        // Reset asserted during FLUSH.
        for (int j = 0; j < NM; j++) src[j] = ($urandom_range(0, 1) == 1);
        load_model();
        kick();
        for (int t = 0; t < 200 && (cyc - base) != NM + 2; t++) begin
            @(negedge clk);
            #1;
        end
        chk("reached_flush", cyc - base, NM + 2);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_rd_en", int'(rd_en), 0);
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_rd_addr", int'(rd_addr), 0);
        chk("midrst_wr_addr", int'(wr_addr), 0);
        chk("midrst_wr_data", int'(wr_data), 0);
        q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_after_rst", int'(busy), 0);

        // Clean blinker generation after the aborted one.
        clear_src();
        set_cell(2, 3); set_cell(2, 4); set_cell(2, 5);
        run_gen(1'b0);
        chk("blinker2_count", live_cnt(), 3);
        chk("blinker2_20", int'(dst[20]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
